// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared constants for the MEM/WB stage: default widths, writeback-select and
// load-type encodings, FSM state encoding, the captured control payload and a
// write-enable helper shared by the ALU/PC4 and load completion paths.
// -----------------------------------------------------------------------------
package wb_stage_pkg;

    localparam int unsigned WORD_WIDTH_DEF     = 32;
    localparam int unsigned REG_ADDR_WIDTH_DEF = 5;
    localparam int unsigned SEL_WB_WIDTH       = 2;
    localparam int unsigned LOAD_TYPE_WIDTH    = 3;
    localparam int unsigned BYTE_OFF_WIDTH     = 2;

    // Writeback mux select
    typedef enum logic [SEL_WB_WIDTH-1:0] {
        SEL_WB_ALUOUT  = 2'b00,
        SEL_WB_DM      = 2'b01,
        SEL_WB_PC4     = 2'b10,
        SEL_WB_ILLEGAL = 2'b11
    } sel_wb_e;

    // Load extraction type; unlisted codes behave as LW
    typedef enum logic [LOAD_TYPE_WIDTH-1:0] {
        LOAD_LW  = 3'b000,
        LOAD_LB  = 3'b001,
        LOAD_LBU = 3'b010,
        LOAD_LH  = 3'b011,
        LOAD_LHU = 3'b100
    } load_type_e;

    // Stage FSM
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WB      = 2'b01,
        ST_WAIT_DM = 2'b10
    } wb_state_e;

    // Control fields latched at capture
    typedef struct packed {
        logic                       reg_write;
        logic [SEL_WB_WIDTH-1:0]    sel_wb;
        logic [LOAD_TYPE_WIDTH-1:0] load_type;
        logic [BYTE_OFF_WIDTH-1:0]  byte_off;
    } wb_ctl_t;

    // Register-file write qualifier: $0 and the illegal select never write
    function automatic logic wb_write_en(input logic                    reg_write,
                                         input logic                    waddr_nz,
                                         input logic [SEL_WB_WIDTH-1:0] sel_wb);
        return reg_write && waddr_nz && (sel_wb != SEL_WB_ILLEGAL);
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if
// Bundles the MEM->WB handshake, the DM read response, flush and the
// register-file write port of wb_stage.
//   master : memory-stage / environment side (drives in_*, dm_*, flush)
//   slave  : wb_stage side (drives in_ready, rf_*, retire)
// Signals:
//   in_valid, in_ready              upstream valid/ready handshake
//   in_aluout, in_pc4               result candidates (aluout is also DM addr)
//   in_waddr, in_reg_write          destination register and write intent
//   in_sel_wb, in_load_type         writeback select, load extraction type
//   in_byte_off                     load address bits [1:0]
//   dm_rvalid, dm_rdata             single-cycle DM read response
//   flush                           kill stage content
//   rf_we, rf_waddr, rf_wdata       register-file write port
//   retire                          one pulse per completed instruction
// -----------------------------------------------------------------------------
interface wb_stage_if #(
    parameter int unsigned WORD_WIDTH     = wb_stage_pkg::WORD_WIDTH_DEF,
    parameter int unsigned REG_ADDR_WIDTH = wb_stage_pkg::REG_ADDR_WIDTH_DEF
);
    import wb_stage_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [WORD_WIDTH-1:0]      in_aluout;
    logic [WORD_WIDTH-1:0]      in_pc4;
    logic [REG_ADDR_WIDTH-1:0]  in_waddr;
    logic                       in_reg_write;
    logic [SEL_WB_WIDTH-1:0]    in_sel_wb;
    logic [LOAD_TYPE_WIDTH-1:0] in_load_type;
    logic [BYTE_OFF_WIDTH-1:0]  in_byte_off;
    logic                       dm_rvalid;
    logic [WORD_WIDTH-1:0]      dm_rdata;
    logic                       flush;
    logic                       rf_we;
    logic [REG_ADDR_WIDTH-1:0]  rf_waddr;
    logic [WORD_WIDTH-1:0]      rf_wdata;
    logic                       retire;

    modport master (
        output in_valid, in_aluout, in_pc4, in_waddr, in_reg_write,
               in_sel_wb, in_load_type, in_byte_off, dm_rvalid, dm_rdata, flush,
        input  in_ready, rf_we, rf_waddr, rf_wdata, retire
    );

    modport slave (
        input  in_valid, in_aluout, in_pc4, in_waddr, in_reg_write,
               in_sel_wb, in_load_type, in_byte_off, dm_rvalid, dm_rdata, flush,
        output in_ready, rf_we, rf_waddr, rf_wdata, retire
    );

endinterface

// File: rtl/wb_stage_load_ext.sv
// -----------------------------------------------------------------------------
// wb_stage_load_ext
// Combinational load-data extraction: picks the addressed byte/half of a
// little-endian DM word and sign- or zero-extends it.
//   rdata_i     raw DM read word
//   load_type_i LW/LB/LBU/LH/LHU (other codes behave as LW)
//   byte_off_i  address bits [1:0]; bit 0 ignored for halves, both for LW
//   data_o      extended word
// -----------------------------------------------------------------------------
module wb_stage_load_ext
    import wb_stage_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) (
    input  logic [WORD_WIDTH-1:0]      rdata_i,
    input  logic [LOAD_TYPE_WIDTH-1:0] load_type_i,
    input  logic [BYTE_OFF_WIDTH-1:0]  byte_off_i,
    output logic [WORD_WIDTH-1:0]      data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select then extend
    always_comb begin
        byte_sel = rdata_i[{byte_off_i, 3'b000} +: 8];
        half_sel = rdata_i[{byte_off_i[1], 4'b0000} +: 16];
        case (load_type_i)
            LOAD_LB:  data_o = {{(WORD_WIDTH-8){byte_sel[7]}}, byte_sel};
            LOAD_LBU: data_o = {{(WORD_WIDTH-8){1'b0}}, byte_sel};
            LOAD_LH:  data_o = {{(WORD_WIDTH-16){half_sel[15]}}, half_sel};
            LOAD_LHU: data_o = {{(WORD_WIDTH-16){1'b0}}, half_sel};
            default:  data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// MEM/WB pipeline stage. Latches memory-stage results, waits for a
// variable-latency DM read response on loads, extracts/extends load data and
// drives the register-file write port (ALU result, DM data or PC+4).
// Upstream is stalled through in_ready while a load is outstanding.
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   bus (slave)      handshake, DM response, flush, RF write port, retire
//   perf_retired     retired-instruction counter     (WB_PERF_CNT_EN only)
//   perf_load_stall  cycles spent waiting on DM      (WB_PERF_CNT_EN only)
// Optional feature macro: WB_PERF_CNT_EN
// -----------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned WORD_WIDTH     = WORD_WIDTH_DEF,
    parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  bus
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0] perf_retired,
    output logic [31:0] perf_load_stall
`endif
);

    wb_state_e                 state_q, state_d;
    wb_ctl_t                   ctl_q, ctl_d;
    logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                      drop_q, drop_d;
    logic                      rf_we_q, rf_we_d;
    logic                      retire_q, retire_d;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [WORD_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;

    logic                      in_ready_c;
    logic                      capture_c;
    logic                      capture_we_c;
    logic                      load_we_c;
    logic [WORD_WIDTH-1:0]     capture_wdata_c;
    logic [WORD_WIDTH-1:0]     ext_data_c;

    // Load extraction uses the control fields captured with the load
    wb_stage_load_ext #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_load_ext (
        .rdata_i     (bus.dm_rdata),
        .load_type_i (ctl_q.load_type),
        .byte_off_i  (ctl_q.byte_off),
        .data_o      (ext_data_c)
    );

    assign in_ready_c = !bus.flush && (state_q != ST_WAIT_DM);
    assign capture_c  = bus.in_valid && in_ready_c;

    // Next-state, capture and registered-output computation
    always_comb begin
        state_d    = state_q;
        ctl_d      = ctl_q;
        waddr_d    = waddr_q;
        drop_d     = drop_q;
        rf_we_d    = 1'b0;
        retire_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        case (bus.in_sel_wb)
            SEL_WB_ALUOUT: capture_wdata_c = bus.in_aluout;
            SEL_WB_PC4:    capture_wdata_c = bus.in_pc4;
            default:       capture_wdata_c = '0;
        endcase
        capture_we_c = wb_write_en(bus.in_reg_write, |bus.in_waddr, bus.in_sel_wb);
        load_we_c    = wb_write_en(ctl_q.reg_write, |waddr_q, ctl_q.sel_wb);

        if (bus.flush) begin
            state_d = ST_IDLE;
            // A killed load leaves its response in flight unless it lands now
            if (state_q == ST_WAIT_DM) begin
                drop_d = drop_q || !bus.dm_rvalid;
            end else if (bus.dm_rvalid) begin
                drop_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_WAIT_DM: begin
                    if (bus.dm_rvalid) begin
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else begin
                            state_d  = ST_WB;
                            retire_d = 1'b1;
                            rf_we_d  = load_we_c;
                            if (load_we_c) begin
                                rf_waddr_d = waddr_q;
                                rf_wdata_d = ext_data_c;
                            end
                        end
                    end
                end
                default: begin
                    if (bus.dm_rvalid) begin
                        drop_d = 1'b0;
                    end
                    if (capture_c) begin
                        ctl_d   = '{reg_write: bus.in_reg_write,
                                    sel_wb:    bus.in_sel_wb,
                                    load_type: bus.in_load_type,
                                    byte_off:  bus.in_byte_off};
                        waddr_d = bus.in_waddr;
                        if (bus.in_sel_wb == SEL_WB_DM) begin
                            state_d = ST_WAIT_DM;
                        end else begin
                            state_d  = ST_WB;
                            retire_d = 1'b1;
                            rf_we_d  = capture_we_c;
                            if (capture_we_c) begin
                                rf_waddr_d = bus.in_waddr;
                                rf_wdata_d = capture_wdata_c;
                            end
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ctl_q      <= '0;
            waddr_q    <= '0;
            drop_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            retire_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ctl_q      <= ctl_d;
            waddr_q    <= waddr_d;
            drop_q     <= drop_d;
            rf_we_q    <= rf_we_d;
            retire_q   <= retire_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.retire   = retire_q;

`ifdef WB_PERF_CNT_EN
    logic [31:0] perf_retired_q;
    logic [31:0] perf_load_stall_q;

    // Free-running counters, wrap modulo 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired_q    <= '0;
            perf_load_stall_q <= '0;
        end else begin
            if (retire_q) begin
                perf_retired_q <= perf_retired_q + 32'd1;
            end
            if (state_q == ST_WAIT_DM) begin
                perf_load_stall_q <= perf_load_stall_q + 32'd1;
            end
        end
    end

    assign perf_retired    = perf_retired_q;
    assign perf_load_stall = perf_load_stall_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam int unsigned W = 32;
    localparam int unsigned A = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_stage_if #(.WORD_WIDTH(W), .REG_ADDR_WIDTH(A)) bus ();

`ifdef WB_PERF_CNT_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_load_stall;
`endif

    wb_stage #(.WORD_WIDTH(W), .REG_ADDR_WIDTH(A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef WB_PERF_CNT_EN
        ,
        .perf_retired    (perf_retired),
        .perf_load_stall (perf_load_stall)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.in_valid     = 1'b0;
        bus.in_aluout    = '0;
        bus.in_pc4       = '0;
        bus.in_waddr     = '0;
        bus.in_reg_write = 1'b0;
        bus.in_sel_wb    = 2'b00;
        bus.in_load_type = 3'b000;
        bus.in_byte_off  = 2'b00;
        bus.dm_rvalid    = 1'b0;
        bus.dm_rdata     = '0;
        bus.flush        = 1'b0;
    endtask

    task automatic drive_instr(input logic [1:0] sel, input logic [2:0] lt, input logic [1:0] off,
                               input logic [4:0] waddr, input logic rw,
                               input logic [31:0] alu, input logic [31:0] pc4);
        bus.in_valid     = 1'b1;
        bus.in_sel_wb    = sel;
        bus.in_load_type = lt;
        bus.in_byte_off  = off;
        bus.in_waddr     = waddr;
        bus.in_reg_write = rw;
        bus.in_aluout    = alu;
        bus.in_pc4       = pc4;
    endtask

    // Reference load extraction from byte arithmetic
    function automatic logic [31:0] ref_load(input logic [31:0] w, input int lt, input int off);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'h0000_00FF;
        h = (w >> (16 * (off / 2))) & 32'h0000_FFFF;
        case (lt)
            1:       return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            2:       return b;
            3:       return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            4:       return h;
            default: return w;
        endcase
    endfunction

    typedef struct {
        string       name;
        logic [1:0]  sel;
        logic [2:0]  lt;
        logic [1:0]  off;
        logic [4:0]  waddr;
        logic        rw;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] rdata;
        int          lat;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [1:0] sel, input logic [2:0] lt,
                                input logic [1:0] off, input logic [4:0] waddr, input logic rw,
                                input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] rdata,
                                input int lat, input logic exp_we, input logic [31:0] exp_data);
        vec_t v;
        v.name = name; v.sel = sel; v.lt = lt; v.off = off; v.waddr = waddr; v.rw = rw;
        v.alu = alu; v.pc4 = pc4; v.rdata = rdata; v.lat = lat; v.exp_we = exp_we; v.exp_data = exp_data;
        return v;
    endfunction

    vec_t        vecs[14];
    logic [4:0]  last_addr;
    logic [31:0] last_data;

    // Single instruction through the stage; lat = cycles from capture to dm_rvalid
    task automatic run_vec(input vec_t v);
        drive_instr(v.sel, v.lt, v.off, v.waddr, v.rw, v.alu, v.pc4);
        #1 chk({v.name, " ready_at_capture"}, bus.in_ready, 1);
        tick();
        idle_inputs();
        if (v.sel == 2'b01) begin
            for (int k = 1; k < v.lat; k++) begin
                chk({v.name, " ready_while_wait"}, bus.in_ready, 0);
                chk({v.name, " we_while_wait"}, bus.rf_we, 0);
                tick();
            end
            bus.dm_rvalid = 1'b1;
            bus.dm_rdata  = v.rdata;
            #1 chk({v.name, " ready_at_rvalid"}, bus.in_ready, 0);
            tick();
            idle_inputs();
        end
        if (v.exp_we) begin
            last_addr = v.waddr;
            last_data = v.exp_data;
        end
        chk({v.name, " we"}, bus.rf_we, v.exp_we);
        chk({v.name, " retire"}, bus.retire, 1);
        chk({v.name, " waddr"}, bus.rf_waddr, last_addr);
        chk({v.name, " wdata"}, bus.rf_wdata, last_data);
        tick();
        chk({v.name, " we_after"}, bus.rf_we, 0);
        chk({v.name, " retire_after"}, bus.retire, 0);
    endtask

    // Random-phase reference state
    logic        m_load, m_stale, m_we, m_retire;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [4:0]  m_ld_waddr;
    logic        m_ld_rw;
    int          m_ld_lt, m_ld_off;

    task automatic model_reset();
        m_load = 0; m_stale = 0; m_we = 0; m_retire = 0; m_waddr = '0; m_wdata = '0;
        m_ld_waddr = '0; m_ld_rw = 0; m_ld_lt = 0; m_ld_off = 0;
    endtask

    // One clock of the stage as seen from outside, given this cycle's inputs
    task automatic model_step();
        logic resp_to_stale;
        logic wr;
        m_we = 0;
        m_retire = 0;
        resp_to_stale = bus.dm_rvalid && m_stale;
        if (resp_to_stale) m_stale = 0;
        if (bus.flush) begin
            if (m_load && !(bus.dm_rvalid && !resp_to_stale)) m_stale = 1;
            m_load = 0;
        end else if (m_load) begin
            if (bus.dm_rvalid && !resp_to_stale) begin
                m_load = 0;
                m_retire = 1;
                wr = m_ld_rw && (m_ld_waddr != 0);
                if (wr) begin
                    m_we = 1;
                    m_waddr = m_ld_waddr;
                    m_wdata = ref_load(bus.dm_rdata, m_ld_lt, m_ld_off);
                end
            end
        end else if (bus.in_valid) begin
            if (bus.in_sel_wb == 2'b01) begin
                m_load = 1;
                m_ld_waddr = bus.in_waddr;
                m_ld_rw = bus.in_reg_write;
                m_ld_lt = int'(bus.in_load_type);
                m_ld_off = int'(bus.in_byte_off);
            end else begin
                m_retire = 1;
                wr = bus.in_reg_write && (bus.in_waddr != 0) && (bus.in_sel_wb != 2'b11);
                if (wr) begin
                    m_we = 1;
                    m_waddr = bus.in_waddr;
                    m_wdata = (bus.in_sel_wb == 2'b10) ? bus.in_pc4 : bus.in_aluout;
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        last_addr = '0;
        last_data = '0;

        // Reset state
        #1;
        chk("reset rf_we", bus.rf_we, 0);
        chk("reset rf_waddr", bus.rf_waddr, 0);
        chk("reset rf_wdata", bus.rf_wdata, 0);
        chk("reset retire", bus.retire, 0);
        chk("reset in_ready", bus.in_ready, 1);
        tick(); tick();
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single-instruction vectors
        vecs[0]  = mk("alu",       2'b00, 3'd0, 2'd0, 5'd8,  1, 32'h0000_0011, 32'h0,         32'h0,         0, 1, 32'h0000_0011);
        vecs[1]  = mk("lb_off3",   2'b01, 3'd1, 2'd3, 5'd3,  1, 32'h0,         32'h0,         32'h80FF_0000, 3, 1, 32'hFFFF_FF80);
        vecs[2]  = mk("lhu_off2",  2'b01, 3'd4, 2'd2, 5'd4,  1, 32'h0,         32'h0,         32'h8001_ABCD, 1, 1, 32'h0000_8001);
        vecs[3]  = mk("lh_off2",   2'b01, 3'd3, 2'd2, 5'd5,  1, 32'h0,         32'h0,         32'h8001_ABCD, 2, 1, 32'hFFFF_8001);
        vecs[4]  = mk("lh_off3",   2'b01, 3'd3, 2'd3, 5'd6,  1, 32'h0,         32'h0,         32'h8001_ABCD, 1, 1, 32'hFFFF_8001);
        vecs[5]  = mk("lbu_off1",  2'b01, 3'd2, 2'd1, 5'd7,  1, 32'h0,         32'h0,         32'h8001_ABCD, 1, 1, 32'h0000_00AB);
        vecs[6]  = mk("lb_off0",   2'b01, 3'd1, 2'd0, 5'd9,  1, 32'h0,         32'h0,         32'h8001_ABCD, 2, 1, 32'hFFFF_FFCD);
        vecs[7]  = mk("lw_off2",   2'b01, 3'd0, 2'd2, 5'd10, 1, 32'h0,         32'h0,         32'h1234_5678, 1, 1, 32'h1234_5678);
        vecs[8]  = mk("ltype7",    2'b01, 3'd7, 2'd1, 5'd11, 1, 32'h0,         32'h0,         32'hDEAD_BEEF, 1, 1, 32'hDEAD_BEEF);
        vecs[9]  = mk("lh_pos",    2'b01, 3'd3, 2'd0, 5'd12, 1, 32'h0,         32'h0,         32'hFFFF_7FFF, 1, 1, 32'h0000_7FFF);
        vecs[10] = mk("write_r0",  2'b00, 3'd0, 2'd0, 5'd0,  1, 32'h0000_0005, 32'h0,         32'h0,         0, 0, 32'h0);
        vecs[11] = mk("sel_ill",   2'b11, 3'd0, 2'd0, 5'd4,  1, 32'h0000_0099, 32'h0,         32'h0,         0, 0, 32'h0);
        vecs[12] = mk("no_rw",     2'b00, 3'd0, 2'd0, 5'd6,  0, 32'h0000_0077, 32'h0,         32'h0,         0, 0, 32'h0);
        vecs[13] = mk("jal",       2'b10, 3'd0, 2'd0, 5'd31, 1, 32'h0000_0123, 32'h0040_0008, 32'h0,         0, 1, 32'h0040_0008);
        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back ALU ops, no bubble
        drive_instr(2'b00, 3'd0, 2'd0, 5'd8, 1, 32'h11, 32'h0);
        #1 chk("b2b ready0", bus.in_ready, 1);
        tick();
        drive_instr(2'b00, 3'd0, 2'd0, 5'd9, 1, 32'h22, 32'h0);
        #1 chk("b2b ready1", bus.in_ready, 1);
        chk("b2b we0", bus.rf_we, 1);
        chk("b2b addr0", bus.rf_waddr, 8);
        chk("b2b data0", bus.rf_wdata, 32'h11);
        tick();
        idle_inputs();
        chk("b2b we1", bus.rf_we, 1);
        chk("b2b addr1", bus.rf_waddr, 9);
        chk("b2b data1", bus.rf_wdata, 32'h22);
        tick();
        chk("b2b we_end", bus.rf_we, 0);

        // Flush while WB entry present: entry still writes, no capture
        drive_instr(2'b00, 3'd0, 2'd0, 5'd2, 1, 32'h33, 32'h0);
        tick();
        drive_instr(2'b00, 3'd0, 2'd0, 5'd3, 1, 32'h44, 32'h0);
        bus.flush = 1'b1;
        #1 chk("fwb ready", bus.in_ready, 0);
        chk("fwb we_committed", bus.rf_we, 1);
        chk("fwb data_committed", bus.rf_wdata, 32'h33);
        tick();
        idle_inputs();
        chk("fwb no_capture_we", bus.rf_we, 0);
        chk("fwb no_capture_retire", bus.retire, 0);
        tick();

        // Flush in WAIT_DM, stale response in IDLE, then fresh LW
        drive_instr(2'b01, 3'd0, 2'd0, 5'd13, 1, 32'h0, 32'h0);
        tick();
        idle_inputs();
        bus.flush = 1'b1;
        tick();
        idle_inputs();
        chk("fdm we", bus.rf_we, 0);
        chk("fdm retire", bus.retire, 0);
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'hBAD0_BAD0;
        tick();
        idle_inputs();
        chk("fdm stale_we", bus.rf_we, 0);
        run_vec(mk("fdm_lw", 2'b01, 3'd0, 2'd0, 5'd14, 1, 32'h0, 32'h0, 32'h1234_5678, 1, 1, 32'h1234_5678));

        // Flush in WAIT_DM, stale response lands during the next load's wait
        drive_instr(2'b01, 3'd0, 2'd0, 5'd15, 1, 32'h0, 32'h0);
        tick();
        idle_inputs();
        bus.flush = 1'b1;
        tick();
        idle_inputs();
        drive_instr(2'b01, 3'd0, 2'd0, 5'd16, 1, 32'h0, 32'h0);
        tick();
        idle_inputs();
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'hBAD0_BAD0;
        tick();
        idle_inputs();
        #1 chk("stale2 ready", bus.in_ready, 0);
        chk("stale2 we", bus.rf_we, 0);
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'hCAFE_F00D;
        tick();
        idle_inputs();
        chk("stale2 real_we", bus.rf_we, 1);
        chk("stale2 real_addr", bus.rf_waddr, 16);
        chk("stale2 real_data", bus.rf_wdata, 32'hCAFE_F00D);
        tick();

        // JAL then asynchronous reset mid-load
        run_vec(mk("jal2", 2'b10, 3'd0, 2'd0, 5'd31, 1, 32'h0, 32'h0040_0008, 32'h0, 0, 1, 32'h0040_0008));
        drive_instr(2'b01, 3'd0, 2'd0, 5'd17, 1, 32'h0, 32'h0);
        tick();
        idle_inputs();
        #1 chk("rst ready_before", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("rst rf_we", bus.rf_we, 0);
        chk("rst rf_waddr", bus.rf_waddr, 0);
        chk("rst rf_wdata", bus.rf_wdata, 0);
        chk("rst retire", bus.retire, 0);
        chk("rst in_ready", bus.in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        tick();
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'h5555_5555;
        tick();
        idle_inputs();
        chk("rst late_rvalid_we", bus.rf_we, 0);
        chk("rst late_rvalid_retire", bus.retire, 0);
        last_addr = '0;
        last_data = '0;
        run_vec(mk("post_rst", 2'b00, 3'd0, 2'd0, 5'd1, 1, 32'hA5A5_0001, 32'h0, 32'h0, 0, 1, 32'hA5A5_0001));

        // Randomized traffic against the reference model
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        tick();
        for (int c = 0; c < 1500; c++) begin
            bus.in_valid     = 1'($urandom_range(0, 1));
            bus.in_sel_wb    = 2'($urandom_range(0, 3));
            bus.in_load_type = 3'($urandom_range(0, 7));
            bus.in_byte_off  = 2'($urandom_range(0, 3));
            bus.in_waddr     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            bus.in_reg_write = ($urandom_range(0, 5) != 0);
            bus.in_aluout    = $urandom;
            bus.in_pc4       = $urandom;
            bus.dm_rvalid    = ($urandom_range(0, 99) < 35);
            bus.dm_rdata     = $urandom;
            bus.flush        = ($urandom_range(0, 99) < 6);
            #1 chk("rnd in_ready", bus.in_ready, !bus.flush && !m_load);
            model_step();
            tick();
            chk("rnd rf_we", bus.rf_we, m_we);
            chk("rnd retire", bus.retire, m_retire);
            chk("rnd rf_waddr", bus.rf_waddr, m_waddr);
            chk("rnd rf_wdata", bus.rf_wdata, m_wdata);
        end
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline stage that latches memory-stage results.
- Waits on a variable-latency data-memory read response.
- Extracts and sign- or zero-extends load data.
- Drives the register-file write port and selects between ALU result, DM data and PC+4.
- Sits between the memory stage and the register file; stalls upstream through a valid/ready handshake while a load is outstanding.

Parameters:
- WORD_WIDTH, 32, datapath width.
- REG_ADDR_WIDTH, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_aluout  in  WORD_WIDTH  ALU result; also the DM address source
- in_pc4  in  WORD_WIDTH  PC+4 of the instruction
- in_waddr  in  REG_ADDR_WIDTH  destination register, already resolved (rt/rd/ra)
- in_reg_write  in  1  instruction writes the register file
- in_sel_wb  in  2  00 ALUOUT, 01 DM, 10 PC4, 11 illegal
- in_load_type  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU
- in_byte_off  in  2  address bits [1:0] of the load
- dm_rvalid  in  1  DM read data valid, single-cycle pulse
- dm_rdata  in  WORD_WIDTH  raw DM read word, little-endian
- flush  in  1  kill stage content
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_ADDR_WIDTH  register-file write address
- rf_wdata  out  WORD_WIDTH  register-file write data
- retire  out  1  one-cycle pulse per completed instruction

Behaviour:
- FSM states: IDLE (empty), WB (entry complete, writing), WAIT_DM (load outstanding). Reset puts the FSM in IDLE.
- Reset values: all field registers 0, drop_pending=0. Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, retire=0, in_ready=1.
- in_ready = !flush && state!=WAIT_DM.
- Capture occurs on in_valid && in_ready, latching all in_* fields.
  - sel_wb != 01: next state WB. Captured wdata = aluout for 00, pc4 for 10, 0 for 11.
  - sel_wb == 01: next state WAIT_DM.
- WB lasts exactly one cycle.
  - rf_we = reg_write && waddr!=0 && sel_wb!=11.
  - retire=1 in this cycle.
  - Next state is WB/WAIT_DM if a capture happens the same cycle (back-to-back, no bubble), else IDLE.
- WAIT_DM:
  - On dm_rvalid && !drop_pending: register the extracted load data and go to WB.
  - A load therefore writes 1 cycle after dm_rvalid. Minimum capture-to-write latency is 2 cycles when dm_rvalid arrives in the first WAIT_DM cycle.
- Load extraction:
  - LB/LBU select byte byte_off.
  - LH/LHU select half byte_off[1]; byte_off[0] is ignored.
  - LW ignores byte_off.
  - Sign- or zero-extend to WORD_WIDTH.
  - Undefined load_type behaves as LW.
- rf_waddr and rf_wdata are driven from registers. They hold their last value while rf_we=0.
- Flush:
  - Takes priority over everything; next state is IDLE and no capture occurs that cycle.
  - A WB entry present during flush still writes in that cycle, because it is already committed.
  - Flush in WAIT_DM discards the load and sets drop_pending unless dm_rvalid is high that same cycle.
  - The next dm_rvalid while drop_pending=1 is ignored and clears drop_pending.
- dm_rvalid in IDLE or WB with drop_pending=0 is ignored.
- Asynchronous reset mid-load returns the FSM to IDLE immediately. No stale-response tracking survives reset.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- When defined, adds outputs perf_retired (32) and perf_load_stall (32), both reset to 0.
  - perf_retired increments on retire.
  - perf_load_stall increments every cycle in WAIT_DM.
  - Both wrap modulo 2^32.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared constants header:
  - SEL_WB_ALUOUT/DM/PC4 encodings, shared with the writeback mux definitions.
  - LOAD_LW/LB/LBU/LH/LHU encodings.
  - FSM state encodings.
- Sub-module load_ext: combinational (dm_rdata, load_type, byte_off) -> extended word.

Test Plan:
- Back-to-back ALU ops: capture waddr=8 aluout=0x11 then waddr=9 aluout=0x22 on consecutive cycles -> rf_we high two consecutive cycles, writing 0x11 then 0x22, with in_ready constantly 1.
- LB with byte_off=3, dm_rvalid 3 cycles after capture, dm_rdata=0x80FF0000 -> in_ready=0 during wait; rf_wdata=0xFFFFFF80 written once 1 cycle after dm_rvalid.
- LHU/LH with byte_off=2, dm_rdata=0x8001ABCD -> LHU writes 0x00008001; LH writes 0xFFFF8001.
- Write to $0 (aluout=0x5) and sel_wb=11 -> rf_we stays 0 and retire still pulses.
- Flush during WAIT_DM, then stale dm_rvalid, then a new LW with dm_rdata=0x12345678 -> stale response ignored; only 0x12345678 written.
- JAL-style sel_wb=10, pc4=0x00400008, waddr=31; then rst_n low mid-load -> $31 written with 0x00400008; after reset all outputs are 0 and in_ready=1.
